// File: rtl/mips_debug_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the MIPS debug controller.
package mips_debug_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_RUN   = 3'd3;
  localparam logic [2:0] OP_ABORT = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4
  } state_e;

endpackage

// File: rtl/mips_debug_ctrl_if.sv
// Host/core-facing signal bundle of the debug controller; slave is the controller side.
interface mips_debug_ctrl_if
  import mips_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [2:0]        i_cmd_op;
  logic [CNT_W-1:0]  i_cmd_arg;
  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_stop_signal;
  logic              o_cpu_enable;
  logic              o_cpu_hold;
  logic              o_pm_write;
  logic [ADDR_W-1:0] o_pm_addr;
  logic [DATA_W-1:0] o_pm_data;
  logic [CNT_W-1:0]  o_cycle_count;
  logic [2:0]        o_state;
  logic              o_halted;
  logic              o_load_wrap;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_arg, i_wr_valid, i_wr_data, i_stop_signal,
    input  o_cmd_ready, o_cpu_enable, o_cpu_hold, o_pm_write, o_pm_addr, o_pm_data,
           o_cycle_count, o_state, o_halted, o_load_wrap
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_arg, i_wr_valid, i_wr_data, i_stop_signal,
    output o_cmd_ready, o_cpu_enable, o_cpu_hold, o_pm_write, o_pm_addr, o_pm_data,
           o_cycle_count, o_state, o_halted, o_load_wrap
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear has priority over count.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_debug_ctrl.sv
// Run/step/program-load controller sitting between the debug host and the MIPS core.
module mips_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  mips_debug_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic              halted_q, halted_d;
  logic              wrap_q, wrap_d;

  logic cmd_ready, accept, abort_acc, cnt_clear;
  logic cpu_enable, cpu_hold, pm_write;
  logic [CNT_W-1:0] cycle_count;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HALT);
  // ABORT bypasses the ready gate so the host can always regain control.
  assign accept    = bus.i_cmd_valid && (cmd_ready || (bus.i_cmd_op == OP_ABORT));
  assign abort_acc = accept && (bus.i_cmd_op == OP_ABORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      halted_q <= halted_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    halted_d   = halted_q;
    wrap_d     = wrap_q;
    cnt_clear  = 1'b0;
    cpu_enable = 1'b0;
    cpu_hold   = 1'b0;
    pm_write   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (accept) begin
          case (bus.i_cmd_op)
            OP_LOAD: begin
              state_d   = ST_LOAD;
              addr_d    = '0;
              remain_d  = bus.i_cmd_arg;
              halted_d  = 1'b0;
              wrap_d    = 1'b0;
              cnt_clear = 1'b1;
            end
            OP_STEP: begin
              if (state_q == ST_IDLE) begin
                state_d  = ST_STEP;
                remain_d = (bus.i_cmd_arg == '0) ? CNT_W'(1) : bus.i_cmd_arg;
              end
            end
            OP_RUN: begin
              if (state_q == ST_IDLE) state_d = ST_RUN;
            end
            OP_ABORT: state_d = ST_IDLE;
            OP_CLEAR: begin
              state_d   = ST_IDLE;
              halted_d  = 1'b0;
              wrap_d    = 1'b0;
              cnt_clear = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        cpu_hold = 1'b1;
        if (abort_acc || (remain_q == '0)) begin
          state_d = ST_IDLE;
        end else if (bus.i_wr_valid) begin
          pm_write = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (&addr_q) wrap_d = 1'b1;
          if (remain_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        cpu_enable = 1'b1;
        if (abort_acc) begin
          state_d = ST_IDLE;
        end else if (bus.i_stop_signal) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          remain_d = '0;
        end else if (remain_q <= CNT_W'(1)) begin
          state_d  = ST_IDLE;
          remain_d = '0;
        end else begin
          remain_d = remain_q - 1'b1;
        end
      end

      ST_RUN: begin
        cpu_enable = 1'b1;
        if (abort_acc) begin
          state_d = ST_IDLE;
        end else if (bus.i_stop_signal) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (cpu_enable),
    .clr_i   (cnt_clear),
    .count_o (cycle_count)
  );

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_cpu_enable  = cpu_enable;
  assign bus.o_cpu_hold    = cpu_hold;
  assign bus.o_pm_write    = pm_write;
  assign bus.o_pm_addr     = addr_q;
  assign bus.o_pm_data     = pm_write ? bus.i_wr_data : {DATA_W{1'b0}};
  assign bus.o_cycle_count = cycle_count;
  assign bus.o_state       = state_q;
  assign bus.o_halted      = halted_q;
  assign bus.o_load_wrap   = wrap_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Randomised bench for mips_debug_ctrl against a transaction-level model of load/step/run.
module tb_mips_debug_ctrl;
  import mips_debug_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int MAX_CNT = 65535;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_debug_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();
  mips_debug_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4))  bus4 ();

  mips_debug_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mips_debug_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the host should observe, in transaction terms.
  int          exp_cnt;
  bit          exp_halted;
  bit          exp_wrap;
  logic [31:0] exp_mem [256];
  logic [31:0] obs_mem [256];
  bit          exp_valid [256];
  int          wr_seen;
  int          en_seen;

  function automatic void add_cycles(input int k);
    exp_cnt = (exp_cnt + k > MAX_CNT) ? MAX_CNT : exp_cnt + k;
  endfunction

  initial begin
    wr_seen = 0;
    en_seen = 0;
    forever begin
      @(negedge clk);
      #3;
      if (bus.o_pm_write) begin
        obs_mem[bus.o_pm_addr] = bus.o_pm_data;
        wr_seen++;
      end
      if (bus.o_cpu_enable) en_seen++;
    end
  end

  task automatic drive(input logic cv, input logic [2:0] op, input logic [15:0] arg,
                       input logic wv, input logic [31:0] wd, input logic stop);
    @(negedge clk);
    bus.i_cmd_valid   = cv;
    bus.i_cmd_op      = op;
    bus.i_cmd_arg     = arg;
    bus.i_wr_valid    = wv;
    bus.i_wr_data     = wd;
    bus.i_stop_signal = stop;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, OP_NOP, 16'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Commands other than ABORT, issued while busy; they must be ignored.
  function automatic logic [2:0] junk_op();
    logic [2:0] o;
    o = 3'($urandom_range(0, 7));
    if (o == OP_ABORT) o = OP_CLEAR;
    return o;
  endfunction

  task automatic junk(input logic wv, input logic [31:0] wd, input logic stop);
    drive(1'($urandom_range(0, 1)), junk_op(), 16'($urandom), wv, wd, stop);
  endtask

  task automatic send(input logic [2:0] op, input int arg);
    drive(1'b1, op, 16'(arg), 1'b0, 32'd0, 1'b0);
    check_eq("cmd_ready", bus.o_cmd_ready, 1'b1);
  endtask

  task automatic do_load(input int n, input bit fixed);
    logic [31:0] tbl [3];
    logic [31:0] wd;
    int w0;
    tbl[0] = 32'h20080005;
    tbl[1] = 32'h20090003;
    tbl[2] = 32'h01095020;
    w0 = wr_seen;
    send(OP_LOAD, n);
    exp_cnt    = 0;
    exp_halted = 1'b0;
    exp_wrap   = 1'b0;
    if (n == 0) begin
      drive(1'b0, OP_NOP, 16'd0, 1'b1, $urandom, 1'b0);
      check_eq("load0_hold", bus.o_cpu_hold, 1'b1);
      check_eq("load0_nowrite", bus.o_pm_write, 1'b0);
    end
    for (int k = 0; k < n; k++) begin
      repeat (fixed ? 0 : $urandom_range(0, 2)) begin
        junk(1'b0, $urandom, 1'($urandom_range(0, 1)));
        check_eq("load_gap_hold", bus.o_cpu_hold, 1'b1);
        check_eq("load_gap_write", bus.o_pm_write, 1'b0);
      end
      wd = fixed && k < 3 ? tbl[k] : $urandom;
      drive(1'b0, OP_NOP, 16'd0, 1'b1, wd, 1'b0);
      check_eq("load_write", bus.o_pm_write, 1'b1);
      check_eq("load_addr", bus.o_pm_addr, 64'(k % 256));
      check_eq("load_data", bus.o_pm_data, wd);
      check_eq("load_hold", bus.o_cpu_hold, 1'b1);
      exp_mem[k % 256]   = wd;
      exp_valid[k % 256] = 1'b1;
      if (k % 256 == 255) exp_wrap = 1'b1;
    end
    idle();
    check_eq("load_done_state", bus.o_state, ST_IDLE);
    check_eq("load_done_hold", bus.o_cpu_hold, 1'b0);
    check_eq("load_wrap", bus.o_load_wrap, exp_wrap);
    check_eq("load_count", bus.o_cycle_count, 64'(exp_cnt));
    check_eq("load_halted", bus.o_halted, 1'b0);
    check_eq("load_nwords", 64'(wr_seen - w0), 64'(n));
  endtask

  task automatic do_step(input int n, input int stop_at);
    int m;
    int k;
    int e0;
    m  = (n == 0) ? 1 : n;
    k  = (stop_at != 0) ? stop_at : m;
    e0 = en_seen;
    send(OP_STEP, n);
    for (int i = 1; i <= k; i++) begin
      junk(1'b0, 32'd0, 1'(i == stop_at));
      check_eq("step_enable", bus.o_cpu_enable, 1'b1);
    end
    add_cycles(k);
    if (stop_at != 0) exp_halted = 1'b1;
    drive(1'b0, OP_NOP, 16'd0, 1'b0, 32'd0, 1'($urandom_range(0, 1)));
    check_eq("step_end_enable", bus.o_cpu_enable, 1'b0);
    check_eq("step_end_state", bus.o_state, exp_halted ? ST_HALT : ST_IDLE);
    check_eq("step_halted", bus.o_halted, exp_halted);
    check_eq("step_count", bus.o_cycle_count, 64'(exp_cnt));
    check_eq("step_pulses", 64'(en_seen - e0), 64'(k));
  endtask

  task automatic do_run(input int k, input bit abort);
    send(OP_RUN, $urandom);
    for (int i = 1; i <= k; i++) begin
      if (abort && i == k) drive(1'b1, OP_ABORT, 16'd0, 1'b0, 32'd0, 1'b0);
      else junk(1'b0, 32'd0, 1'(!abort && i == k));
      check_eq("run_enable", bus.o_cpu_enable, 1'b1);
    end
    add_cycles(k);
    if (!abort) exp_halted = 1'b1;
    idle();
    check_eq("run_end_enable", bus.o_cpu_enable, 1'b0);
    check_eq("run_end_state", bus.o_state, abort ? ST_IDLE : ST_HALT);
    check_eq("run_halted", bus.o_halted, exp_halted);
    check_eq("run_count", bus.o_cycle_count, 64'(exp_cnt));
  endtask

  task automatic halt_probe();
    send(OP_STEP, 3);
    idle();
    check_eq("halt_step_state", bus.o_state, ST_HALT);
    check_eq("halt_step_enable", bus.o_cpu_enable, 1'b0);
    send(OP_RUN, 0);
    idle();
    check_eq("halt_run_state", bus.o_state, ST_HALT);
    check_eq("halt_count", bus.o_cycle_count, 64'(exp_cnt));
  endtask

  task automatic do_clear();
    send(OP_CLEAR, $urandom);
    exp_cnt    = 0;
    exp_halted = 1'b0;
    exp_wrap   = 1'b0;
    idle();
    check_eq("clear_state", bus.o_state, ST_IDLE);
    check_eq("clear_halted", bus.o_halted, 1'b0);
    check_eq("clear_wrap", bus.o_load_wrap, 1'b0);
    check_eq("clear_count", bus.o_cycle_count, 64'd0);
  endtask

  task automatic abort_load();
    logic [31:0] wd;
    int w0;
    w0 = wr_seen;
    send(OP_LOAD, 5);
    exp_cnt    = 0;
    exp_halted = 1'b0;
    exp_wrap   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wd = $urandom;
      drive(1'b0, OP_NOP, 16'd0, 1'b1, wd, 1'b0);
      exp_mem[k]   = wd;
      exp_valid[k] = 1'b1;
    end
    drive(1'b1, OP_ABORT, 16'd0, 1'b1, $urandom, 1'b0);
    check_eq("abort_load_nowrite", bus.o_pm_write, 1'b0);
    drive(1'b0, OP_NOP, 16'd0, 1'b1, $urandom, 1'b0);
    check_eq("abort_load_state", bus.o_state, ST_IDLE);
    check_eq("abort_load_hold", bus.o_cpu_hold, 1'b0);
    check_eq("abort_load_write", bus.o_pm_write, 1'b0);
    idle();
    check_eq("abort_load_nwords", 64'(wr_seen - w0), 64'd2);
  endtask

  task automatic recover();
    if ($urandom_range(0, 1) == 0) do_clear();
    else do_load($urandom_range(0, 6), 1'b0);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      if (exp_valid[a]) check_eq(tag, obs_mem[a], exp_mem[a]);
    end
  endtask

  initial begin
    int sel;
    int n;
    exp_cnt    = 0;
    exp_halted = 1'b0;
    exp_wrap   = 1'b0;
    for (int a = 0; a < 256; a++) exp_valid[a] = 1'b0;
    bus.i_cmd_valid    = 1'b0;
    bus.i_cmd_op       = OP_NOP;
    bus.i_cmd_arg      = '0;
    bus.i_wr_valid     = 1'b0;
    bus.i_wr_data      = '0;
    bus.i_stop_signal  = 1'b0;
    bus4.i_cmd_valid   = 1'b0;
    bus4.i_cmd_op      = OP_NOP;
    bus4.i_cmd_arg     = '0;
    bus4.i_wr_valid    = 1'b0;
    bus4.i_wr_data     = '0;
    bus4.i_stop_signal = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    check_eq("rst_ready", bus.o_cmd_ready, 1'b1);
    check_eq("rst_state", bus.o_state, ST_IDLE);
    check_eq("rst_enable", bus.o_cpu_enable, 1'b0);
    check_eq("rst_hold", bus.o_cpu_hold, 1'b0);
    check_eq("rst_write", bus.o_pm_write, 1'b0);
    check_eq("rst_count", bus.o_cycle_count, 64'd0);
    check_eq("rst_halted", bus.o_halted, 1'b0);
    check_eq("rst_wrap", bus.o_load_wrap, 1'b0);

    do_load(3, 1'b1);
    check_mem("load3_mem");
    do_step(4, 0);
    do_step(0, 0);
    do_clear();
    do_run(10, 1'b0);
    halt_probe();
    do_clear();
    do_load(258, 1'b0);
    check_mem("load258_mem");
    abort_load();
    do_run(7, 1'b1);

    repeat (12) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin
          n = $urandom_range(0, 12);
          do_step(n, ($urandom_range(0, 2) == 0) ? $urandom_range(1, (n == 0) ? 1 : n) : 0);
          if (exp_halted) recover();
        end
        1: do_load($urandom_range(0, 8), 1'b0);
        2: begin
          do_run($urandom_range(1, 15), 1'($urandom_range(0, 1)));
          if (exp_halted) recover();
        end
        default: do_clear();
      endcase
    end
    check_mem("rand_mem");

    // Asynchronous reset in the middle of a long STEP.
    send(OP_STEP, 100);
    repeat (5) idle();
    check_eq("pre_rst_enable", bus.o_cpu_enable, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_enable", bus.o_cpu_enable, 1'b0);
    check_eq("mid_rst_state", bus.o_state, ST_IDLE);
    check_eq("mid_rst_count", bus.o_cycle_count, 64'd0);
    check_eq("mid_rst_ready", bus.o_cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    idle();
    check_eq("post_rst_ready", bus.o_cmd_ready, 1'b1);
    check_eq("post_rst_enable", bus.o_cpu_enable, 1'b0);

    // Saturation on the 4-bit counter instance.
    @(negedge clk);
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd_op    = OP_RUN;
    @(negedge clk);
    bus4.i_cmd_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    check_eq("sat_enable", bus4.o_cpu_enable, 1'b1);
    check_eq("sat_count_hold", bus4.o_cycle_count, 64'd15);
    @(negedge clk);
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd_op    = OP_ABORT;
    @(negedge clk);
    bus4.i_cmd_valid = 1'b0;
    #2;
    check_eq("sat_abort_state", bus4.o_state, ST_IDLE);
    check_eq("sat_count_final", bus4.o_cycle_count, 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
